// File: rtl/seq_det_arbiter.sv
// Shares one serial "sequence detector" among NREQ requesters: grant, clear, shift frame MSB-first, count Z hits.
// Define SEQ_DET_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module seq_det_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                         Clk,
   input  logic                         Clr,
   input  logic [NREQ-1:0]              req,
   input  logic [NREQ*WIDTH-1:0]        data,
   output logic [NREQ-1:0]              gnt,
   output logic                         det_clr,
   output logic                         det_x,
   input  logic                         det_z,
   output logic [$clog2(WIDTH+1)-1:0]   hit_cnt,
   output logic                         done,
   output logic [$clog2(NREQ)-1:0]      done_id
);

   localparam int CW = $clog2(WIDTH+1);
   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_e;

   state_e              state_q, state_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic                det_clr_q, det_clr_d;
   logic                det_x_q, det_x_d;
   logic                done_q, done_d;
   logic [CW-1:0]       hit_cnt_q, hit_cnt_d;
   logic [IW-1:0]       done_id_q, done_id_d;
   logic [WIDTH-1:0]    sr_q, sr_d;
   logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [IW-1:0]       id_q, id_d;
`ifndef SEQ_DET_ARB_FIXED_PRIO_EN
   logic [IW-1:0]       last_id_q, last_id_d;
`endif

   logic                pick_found;
   logic [IW-1:0]       pick_id;

   // Scan from lowest to highest precedence so the last hit left standing wins.
   always_comb begin
      pick_found = |req;
      pick_id    = '0;
`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
      for (int k = NREQ-1; k >= 0; k--) begin
         if (req[k]) pick_id = IW'(k);
      end
`else
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last_id_q) + k) % NREQ]) pick_id = IW'((int'(last_id_q) + k) % NREQ);
      end
`endif
   end

   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      gnt_d     = gnt_q;
      det_clr_d = 1'b0;
      det_x_d   = 1'b0;
      done_d    = 1'b0;
      hit_cnt_d = hit_cnt_q;
      done_id_d = done_id_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      id_d      = id_q;
`ifndef SEQ_DET_ARB_FIXED_PRIO_EN
      last_id_d = last_id_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_d     = NREQ'(1) << pick_id;
               sr_d      = data[pick_id*WIDTH +: WIDTH];
               id_d      = pick_id;
               det_clr_d = 1'b1;
               state_d   = CLEAR;
            end
         end
         CLEAR: begin
            hit_cnt_d = '0;
            bit_cnt_d = '0;
            det_x_d   = sr_q[WIDTH-1];
            sr_d      = {sr_q[WIDTH-2:0], 1'b0};
            state_d   = SHIFT;
         end
         SHIFT: begin
            // det_z lags det_x by one cycle, so the first SHIFT cycle has nothing to sample yet.
            if (bit_cnt_q != '0 && det_z) hit_cnt_d = hit_cnt_q + CW'(1);
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(WIDTH-1)) begin
               state_d = DRAIN;
            end else begin
               det_x_d = sr_q[WIDTH-1];
               sr_d    = {sr_q[WIDTH-2:0], 1'b0};
            end
         end
         DRAIN: begin
            if (det_z) hit_cnt_d = hit_cnt_q + CW'(1);
            done_d    = 1'b1;
            done_id_d = id_q;
            gnt_d     = '0;
            state_d   = DONE;
         end
         DONE: begin
`ifndef SEQ_DET_ARB_FIXED_PRIO_EN
            last_id_d = id_q;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         det_clr_q <= 1'b0;
         det_x_q   <= 1'b0;
         done_q    <= 1'b0;
         hit_cnt_q <= '0;
         done_id_q <= '0;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         id_q      <= '0;
`ifndef SEQ_DET_ARB_FIXED_PRIO_EN
         last_id_q <= IW'(NREQ-1);
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         det_clr_q <= det_clr_d;
         det_x_q   <= det_x_d;
         done_q    <= done_d;
         hit_cnt_q <= hit_cnt_d;
         done_id_q <= done_id_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         id_q      <= id_d;
`ifndef SEQ_DET_ARB_FIXED_PRIO_EN
         last_id_q <= last_id_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign det_clr = det_clr_q;
   assign det_x   = det_x_q;
   assign done    = done_q;
   assign hit_cnt = hit_cnt_q;
   assign done_id = done_id_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Directed bench for seq_det_arbiter with a registered overlapping-"101" Moore detector model.
// Define SEQ_DET_ARB_FIXED_PRIO_EN here as for the RTL to check the fixed-priority build.
module tb_seq_det_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic        Clk = 1'b0;
   logic        Clr = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] data = '0;
   logic [3:0]  gnt;
   logic        det_clr, det_x, det_z;
   logic [3:0]  hit_cnt;
   logic        done;
   logic [1:0]  done_id;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   seq_det_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .Clk(Clk), .Clr(Clr), .req(req), .data(data), .gnt(gnt),
      .det_clr(det_clr), .det_x(det_x), .det_z(det_z),
      .hit_cnt(hit_cnt), .done(done), .done_id(done_id)
   );

   // Overlapping "101" detector; Z is decoded from registered state so it lags X by one cycle.
   typedef enum logic [1:0] {D_S0, D_S1, D_S2, D_S3} det_e;
   det_e det_st;
   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr)         det_st <= D_S0;
      else if (det_clr) det_st <= D_S0;
      else begin
         case (det_st)
            D_S0:    det_st <= det_x ? D_S1 : D_S0;
            D_S1:    det_st <= det_x ? D_S1 : D_S2;
            D_S2:    det_st <= det_x ? D_S3 : D_S0;
            default: det_st <= det_x ? D_S1 : D_S2;
         endcase
      end
   end
   assign det_z = (det_st == D_S3);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge Clk) if (Clr) check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);

   // Starts on a negedge in IDLE (or CLEAR); returns on the IDLE negedge after the done pulse.
   task automatic frame_check(input logic [1:0] eid, input logic [7:0] ebits,
                              input logic [3:0] ecnt, output int wait_cyc);
      logic [7:0] xs;
      int clr_hi;
      wait_cyc = 0;
      while (!det_clr && wait_cyc < 30) begin
         @(negedge Clk);
         wait_cyc++;
      end
      if (!det_clr) begin
         check("clr_timeout", 32'd0, 32'd1);
         return;
      end
      check("gnt_clear", 32'(gnt), 32'(4'b0001 << eid));
      clr_hi = 0;
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge Clk);
         xs[7-i] = det_x;
         if (det_clr) clr_hi++;
      end
      check("det_x_seq", 32'(xs), 32'(ebits));
      check("clr_width", 32'(clr_hi), 32'd0);
      @(negedge Clk);
      check("drain_x", 32'(det_x), 32'd0);
      check("drain_gnt", 32'(gnt), 32'(4'b0001 << eid));
      check("drain_done", 32'(done), 32'd0);
      @(negedge Clk);
      check("done", 32'(done), 32'd1);
      check("done_id", 32'(done_id), 32'(eid));
      check("hit_cnt", 32'(hit_cnt), 32'(ecnt));
      check("done_gnt", 32'(gnt), 32'd0);
      @(negedge Clk);
      check("done_pulse", 32'(done), 32'd0);
      check("hit_hold", 32'(hit_cnt), 32'(ecnt));
   endtask

   logic [7:0] fr  [4] = '{8'b10100000, 8'b10101010, 8'hFF, 8'b00000101};
   logic [3:0] fhit[4] = '{4'd1, 4'd3, 4'd0, 4'd1};
`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
   logic [1:0] rr_exp[5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
   logic [1:0] p7_exp[3] = '{2'd1, 2'd1, 2'd1};
`else
   logic [1:0] rr_exp[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [1:0] p7_exp[3] = '{2'd3, 2'd1, 2'd3};
`endif

   initial begin
      int t;
      repeat (2) @(negedge Clk);
      check("rst_outputs", {gnt, det_clr, det_x, done, hit_cnt, done_id}, 32'd0);
      Clr = 1'b1;

      // Abort a frame in its 4th SHIFT cycle, then let the held request restart it.
      data[7:0] = 8'b10110100;
      req = 4'b0001;
      t = 0;
      while (!det_clr && t < 30) begin
         @(negedge Clk);
         t++;
      end
      check("rst_first_clr", 32'(det_clr), 32'd1);
      repeat (4) @(negedge Clk);
      #2 Clr = 1'b0;
      #1 check("rst_async", {gnt, det_clr, det_x, done, hit_cnt, done_id}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("rst_no_done", 32'(done), 32'd0);
      end
      Clr = 1'b1;
      frame_check(2'd0, 8'b10110100, 4'd2, t);
      check("rst_regrant_lat", 32'(t), 32'd1);

      // Single frames back to back from requester 0, then one idle.
      data[7:0] = 8'b10101000;
      frame_check(2'd0, 8'b10101000, 4'd2, t);
      check("latency", 32'(t), 32'd1);
      data[7:0] = 8'hFF;
      frame_check(2'd0, 8'hFF, 4'd0, t);
      req = 4'b0000;
      repeat (2) @(negedge Clk);

      req = 4'b0010;
      data[15:8] = 8'b10101010;
      frame_check(2'd1, 8'b10101010, 4'd3, t);
      req = 4'b0000;
      @(negedge Clk);

      // Last hit only visible in the DRAIN sample.
      req = 4'b1000;
      data[31:24] = 8'b00000101;
      frame_check(2'd3, 8'b00000101, 4'd1, t);
      req = 4'b0000;
      @(negedge Clk);

      for (int i = 0; i < 4; i++) data[i*8 +: 8] = fr[i];
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         frame_check(rr_exp[k], fr[rr_exp[k]], fhit[rr_exp[k]], t);
         check("idle_gap", 32'(t), 32'd1);
      end
      req = 4'b0000;
      repeat (2) @(negedge Clk);

      // One-cycle request from requester 2; data changed right after grant must not matter.
      req = 4'b0100;
      data[23:16] = 8'b10100000;
      @(negedge Clk);
      req = 4'b0000;
      data[23:16] = 8'h00;
      frame_check(2'd2, 8'b10100000, 4'd1, t);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("idle_hit_stable", 32'(hit_cnt), 32'd1);
         check("idle_quiet", {gnt, done}, 32'd0);
      end

      data[15:8]  = 8'b10101010;
      data[31:24] = 8'b00000101;
      req = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         frame_check(p7_exp[k], fr[p7_exp[k]], fhit[p7_exp[k]], t);
      end
      req = 4'b0000;
      repeat (2) @(negedge Clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
